dwrr_var_pkt_arb: RTL and testbench
===================================

// Module: dwrr_var_pkt_arb
// PURPOSE
//  Deficit weighted round-robin arbiter for variable-length packets across NUM_REQS queues.
//  Each queue presents a head-packet length; credits accumulate per visit and carry over.
//  The rotation skips idle queues, and credits are saturating.
//  Sits between per-queue head-of-line logic and a shared output link; gnt pops one packet.
// PARAMETERS
//  NUM_REQS  4                   number of requestors (>=2)
//  QWID      8                   deficit-counter and quantum width
//  LWID      6                   packet-length width; elaboration check: 2**LWID-1 <= 2**QWID-1
//  CNTWID    $clog2(NUM_REQS)    index width (derived; do not override)
// PORTS
//  clk             in   1                 clock, rising edge
//  rst             in   1                 synchronous, active-high reset
//  blk             in   1                 downstream stall: freeze all state, no grants
//  reqs            in   NUM_REQS          queue i non-empty
//  req_lens        in   NUM_REQS*LWID     head-packet length of queue i, slice [(i+1)*LWID-1:i*LWID]
//  input_quantums  in   NUM_REQS*QWID     per-queue quantum, same slicing; sampled on each visit entry
//  gnt             out  NUM_REQS          one-hot grant, pop head of queue i this cycle
//  gnt_len         out  LWID              length of granted packet; 0 when no grant
//  gnt_idx         out  CNTWID            index of granted queue; 0 when no grant
//  cur_sel         out  CNTWID            registered currently-visited queue
//  busy            out  1                 state==SERVE
// BEHAVIOUR
//  Registered state: st{IDLE,SERVE}, sel, def_cnt[NUM_REQS]. Outputs are combinational from state+inputs.
//  Reset (rst=1 on a clock edge): st=IDLE, sel=NUM_REQS-1, every def_cnt=0.
//   While rst=1: gnt=0, gnt_len=0, gnt_idx=0, busy=0, cur_sel reflects sel.
//  len(i) = req_lens slice i; a value of 0 is treated as 1 everywhere.
//  ok = st==SERVE & reqs[sel] & def_cnt[sel]>=len(sel) & ~blk & ~rst.
//   gnt[sel]=ok, zero-latency (same cycle as the inputs).
//  find(from): first j with reqs[j]=1 in order from+1, from+2, ..., from+NUM_REQS-1, from (mod NUM_REQS).
//  blk=1: no register updates, all grant outputs 0. blk has priority below rst only.
//  IDLE: if any reqs: n=find(sel); sel<=n; def_cnt[n]<=sat(def_cnt[n]+quantum[n]); st<=SERVE. Else hold.
//  SERVE & ok: def_cnt[sel] <= def_cnt[sel]-len(sel); sel and st hold.
//   Back-to-back grants while credit lasts, one packet per cycle.
//  SERVE & ~ok (leave): if ~reqs[sel], def_cnt[sel]<=0 (DRR empty rule); else the remainder is kept.
//   Then: if any reqs, n=find(sel), sel<=n, def_cnt[n]<=sat(def_cnt[n]+quantum[n]) (stays SERVE); else st<=IDLE.
//   If n==sel (sole requestor), clear-then-add resolves as add onto the cleared/kept value.
//   The leave cycle carries no grant: a visit costs one dead cycle.
//  sat(x): clamp to 2**QWID-1, no wrap. Subtraction never underflows (guarded by >=).
//  quantum=0 is legal: the queue is visited and left with no grant unless it has carried credit.
//  Mid-visit changes of reqs/req_lens are re-evaluated combinationally each cycle.
//  rst mid-visit discards all credit; the first visit after reset starts at queue 0.
// STRUCTURE
//  Package dwrr_pkg: st_t enum {IDLE,SERVE}; function sat_add(QWID); length-normalise function (0->1).
//  Sub-module rr_next_finder #(N): inputs reqs, from; outputs found, idx (rotating priority search).
//  Registers instantiated with the shared FF cell; def_cnt uses a per-queue enable.
// TESTING (NUM_REQS=4, QWID=8, LWID=6)
//  reqs=4'hF, all quantum=8, all len=8 -> gnt idx 0,-,1,-,2,-,3,-,0 (one grant per visit, dead cycle between).
//  quantum[0]=16, others 8, all len=8, all reqs -> queue 0 gets 2 consecutive grants per round, the others 1.
//  only reqs[2]=1, quantum=12, len=8 -> grants per visit 1,2,1,2; def_cnt[2] after visits 4,0,4,0.
//  queue 1 drains (reqs[1]->0) holding def_cnt=5 -> cleared to 0 on leave; next visit starts at quantum[1].
//  reqs=4'b1001 -> visits 0,3,0,3 only; reqs=0 -> busy=0 next cycle, gnt=0.
//  blk=1 for 3 cycles mid-burst -> gnt=0, def_cnt/sel frozen; then rst=1 -> all def_cnt=0, next visit is queue 0.

Source files
------------

// File: rtl/dwrr_pkg.sv
// ============================================================================
//  Module : dwrr_pkg
//  Brief  : Shared types and helpers for the DWRR packet arbiter.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package dwrr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } st_t;

    // Clamps at 2**width-1 instead of wrapping; callers cast the result to width.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    function automatic logic [31:0] norm_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ff_cell.sv
// ============================================================================
//  Module : ff_cell
//  Brief  : Enabled register with synchronous active-high reset.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module ff_cell #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_next_finder.sv
// ============================================================================
//  Module : rr_next_finder
//  Brief  : Rotating-priority search: first set request after 'from', 'from' last.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_next_finder #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  reqs,
    input  logic [CW-1:0] from,
    output logic          found,
    output logic [CW-1:0] idx
);

    logic [CW-1:0] w_j;

    // Walk from lowest to highest priority so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = '0;
        for (int k = N; k >= 1; k--) begin
            w_j = CW'((int'(from) + k) % N);
            if (reqs[w_j]) begin
                found = 1'b1;
                idx   = w_j;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dwrr_var_pkt_arb.sv
// ============================================================================
//  Module : dwrr_var_pkt_arb
//  Brief  : Deficit weighted round-robin arbiter for variable-length packets.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module dwrr_var_pkt_arb #(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int LWID     = 6,
    parameter int CNTWID   = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk,
    input  logic [NUM_REQS-1:0]      reqs,
    input  logic [NUM_REQS*LWID-1:0] req_lens,
    input  logic [NUM_REQS*QWID-1:0] input_quantums,
    output logic [NUM_REQS-1:0]      gnt,
    output logic [LWID-1:0]          gnt_len,
    output logic [CNTWID-1:0]        gnt_idx,
    output logic [CNTWID-1:0]        cur_sel,
    output logic                     busy
);

    import dwrr_pkg::*;

    localparam logic [CNTWID-1:0] c_SEL_RST = CNTWID'(NUM_REQS - 1);

    if (LWID > QWID) begin : g_bad_params
        $error("dwrr_var_pkt_arb: LWID must not exceed QWID");
    end

    logic [LWID-1:0]     w_len     [NUM_REQS];
    logic [QWID-1:0]     w_quant   [NUM_REQS];
    logic [QWID-1:0]     r_def_cnt [NUM_REQS];
    logic [QWID-1:0]     w_def_nxt [NUM_REQS];
    logic [NUM_REQS-1:0] w_def_we;

    st_t                 r_st;
    st_t                 w_st_nxt;
    logic [0:0]          w_st_q;
    logic [CNTWID-1:0]   r_sel;
    logic [CNTWID-1:0]   w_sel_nxt;
    logic                w_found;
    logic [CNTWID-1:0]   w_next;
    logic                w_ok;
    logic [LWID-1:0]     w_len_sel;
    logic [QWID-1:0]     w_def_sel;
    logic [QWID-1:0]     w_keep;
    logic [QWID-1:0]     w_base;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_queue
        assign w_len[i]   = LWID'(norm_len(32'(req_lens[i*LWID +: LWID])));
        assign w_quant[i] = input_quantums[i*QWID +: QWID];

        ff_cell #(.W(QWID), .RST_VAL('0)) u_def_cnt (
            .clk (clk),
            .rst (rst),
            .en  (w_def_we[i]),
            .d   (w_def_nxt[i]),
            .q   (r_def_cnt[i])
        );
    end

    ff_cell #(.W(1), .RST_VAL(1'b0)) u_st (
        .clk (clk),
        .rst (rst),
        .en  (~blk),
        .d   (w_st_nxt),
        .q   (w_st_q)
    );
    assign r_st = st_t'(w_st_q);

    ff_cell #(.W(CNTWID), .RST_VAL(c_SEL_RST)) u_sel (
        .clk (clk),
        .rst (rst),
        .en  (~blk),
        .d   (w_sel_nxt),
        .q   (r_sel)
    );

    rr_next_finder #(.N(NUM_REQS), .CW(CNTWID)) u_finder (
        .reqs  (reqs),
        .from  (r_sel),
        .found (w_found),
        .idx   (w_next)
    );

    assign w_len_sel = w_len[r_sel];
    assign w_def_sel = r_def_cnt[r_sel];
    assign w_ok      = (r_st == SERVE) && reqs[r_sel] &&
                       (w_def_sel >= QWID'(w_len_sel)) && !blk && !rst;

    always_comb begin
        w_st_nxt  = r_st;
        w_sel_nxt = r_sel;
        w_def_we  = '0;
        w_keep    = '0;
        w_base    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_def_nxt[i] = r_def_cnt[i];
        end
        if (!blk) begin
            if (r_st == IDLE) begin
                if (w_found) begin
                    w_def_nxt[w_next] = QWID'(sat_add(32'(r_def_cnt[w_next]),
                                                      32'(w_quant[w_next]), QWID));
                    w_def_we[w_next]  = 1'b1;
                    w_sel_nxt         = w_next;
                    w_st_nxt          = SERVE;
                end
            end else if (w_ok) begin
                w_def_nxt[r_sel] = w_def_sel - QWID'(w_len_sel);
                w_def_we[r_sel]  = 1'b1;
            end else begin
                // An emptied queue forfeits its remainder; a blocked one keeps it.
                w_keep           = reqs[r_sel] ? w_def_sel : '0;
                w_def_nxt[r_sel] = w_keep;
                w_def_we[r_sel]  = 1'b1;
                if (w_found) begin
                    w_base            = (w_next == r_sel) ? w_keep : r_def_cnt[w_next];
                    w_def_nxt[w_next] = QWID'(sat_add(32'(w_base),
                                                      32'(w_quant[w_next]), QWID));
                    w_def_we[w_next]  = 1'b1;
                    w_sel_nxt         = w_next;
                end else begin
                    w_st_nxt = IDLE;
                end
            end
        end
    end

    assign gnt     = w_ok ? ({{(NUM_REQS-1){1'b0}}, 1'b1} << r_sel) : '0;
    assign gnt_len = w_ok ? w_len_sel : '0;
    assign gnt_idx = w_ok ? r_sel : '0;
    assign cur_sel = r_sel;
    assign busy    = (r_st == SERVE) && !rst;

endmodule

`default_nettype wire

// File: tb/tb_dwrr_var_pkt_arb.sv
// ============================================================================
//  Module : tb_dwrr_var_pkt_arb
//  Brief  : Self-checking bench for dwrr_var_pkt_arb (4 queues, QWID=8, LWID=6).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dwrr_var_pkt_arb;

    localparam int N  = 4;
    localparam int QW = 8;
    localparam int LW = 6;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            blk = 1'b0;
    logic [N-1:0]    reqs = '0;
    logic [N*LW-1:0] req_lens = '0;
    logic [N*QW-1:0] input_quantums = '0;
    logic [N-1:0]    gnt;
    logic [LW-1:0]   gnt_len;
    logic [CW-1:0]   gnt_idx;
    logic [CW-1:0]   cur_sel;
    logic            busy;

    dwrr_var_pkt_arb #(.NUM_REQS(N), .QWID(QW), .LWID(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .blk            (blk),
        .reqs           (reqs),
        .req_lens       (req_lens),
        .input_quantums (input_quantums),
        .gnt            (gnt),
        .gnt_len        (gnt_len),
        .gnt_idx        (gnt_idx),
        .cur_sel        (cur_sel),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference state: which queue is being visited, whether a visit is open, credit per queue.
    int m_sel;
    bit m_serve;
    int m_def [N];
    bit m_valid = 1'b0;

    int obs_log [$];
    bit log_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nlen(input int i);
        int l;
        l = int'(req_lens[i*LW +: LW]);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int quant(input int i);
        return int'(input_quantums[i*QW +: QW]);
    endfunction

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    function automatic int find_from(input int from);
        for (int k = 1; k <= N; k++) begin
            if (reqs[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    initial begin : compare
        bit ok;
        int n;
        forever begin
            @(negedge clk);
            ok = 1'b0;
            if (m_valid) begin
                ok = !rst && !blk && m_serve && reqs[m_sel] && (m_def[m_sel] >= nlen(m_sel));
                chk("gnt",     int'(gnt),     ok ? (1 << m_sel) : 0);
                chk("gnt_len", int'(gnt_len), ok ? nlen(m_sel) : 0);
                chk("gnt_idx", int'(gnt_idx), ok ? m_sel : 0);
                chk("cur_sel", int'(cur_sel), m_sel);
                chk("busy",    int'(busy),    (m_serve && !rst) ? 1 : 0);
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("def_cnt%0d", i), int'(dut.r_def_cnt[i]), m_def[i]);
                end
            end
            if (log_en) obs_log.push_back((gnt != '0) ? int'(gnt_idx) : -1);
            @(posedge clk);
            if (rst) begin
                m_serve = 1'b0;
                m_sel   = N - 1;
                for (int i = 0; i < N; i++) m_def[i] = 0;
                m_valid = 1'b1;
            end else if (!blk && m_valid) begin
                if (!m_serve) begin
                    n = find_from(m_sel);
                    if (n >= 0) begin
                        m_def[n] = sat(m_def[n] + quant(n));
                        m_sel    = n;
                        m_serve  = 1'b1;
                    end
                end else if (ok) begin
                    m_def[m_sel] = m_def[m_sel] - nlen(m_sel);
                end else begin
                    if (!reqs[m_sel]) m_def[m_sel] = 0;
                    n = find_from(m_sel);
                    if (n >= 0) begin
                        m_def[n] = sat(m_def[n] + quant(n));
                        m_sel    = n;
                    end else begin
                        m_serve = 1'b0;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_all(input int len, input int q);
        for (int i = 0; i < N; i++) begin
            req_lens[i*LW +: LW]       = LW'(len);
            input_quantums[i*QW +: QW] = QW'(q);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        blk  = 1'b0;
        reqs = '0;
        cyc(2);
        rst = 1'b0;
        obs_log.delete();
        log_en = 1'b1;
    endtask

    task automatic chk_log(input string name, input int exp [$]);
        chk({name, "_count"}, obs_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < obs_log.size()) chk($sformatf("%s[%0d]", name, i), obs_log[i], exp[i]);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int e1 [$] = '{-1, 0, -1, 1, -1, 2, -1, 3, -1, 0};
        int e2 [$] = '{-1, 0, 0, -1, 1, -1, 2, -1, 3, -1, 0, 0};
        int e3 [$] = '{-1, 2, -1, 2, 2, -1, 2, -1, 2, 2};
        int e4 [$] = '{-1, 1, -1, -1};
        int e5 [$] = '{-1, 0, -1, 3, -1, 0, -1, 3};
        int e6 [$] = '{-1, 0, -1, -1, -1, 0, -1, -1};
        int e8 [$] = '{-1, -1, 1, -1, -1, 1};

        cyc(2);
        chk("reset_cur_sel", int'(cur_sel), 3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_gnt", int'(gnt), 0);

        // Equal weights: one packet per visit, a dead cycle between visits.
        do_reset();
        set_all(8, 8);
        reqs = 4'hF;
        cyc(10);
        chk_log("rr_basic", e1);

        // Double quantum on queue 0 yields two packets per round.
        do_reset();
        set_all(8, 8);
        input_quantums[7:0] = 8'd16;
        reqs = 4'hF;
        cyc(12);
        chk_log("weighted", e2);

        // Sole requestor with carry-over credit.
        do_reset();
        set_all(8, 12);
        reqs = 4'b0100;
        cyc(7);
        chk("carry_def2_a", int'(dut.r_def_cnt[2]), 4);
        cyc(3);
        chk("carry_def2_b", int'(dut.r_def_cnt[2]), 0);
        chk_log("carry", e3);

        // A queue that empties loses its leftover credit.
        do_reset();
        set_all(8, 13);
        reqs = 4'b0010;
        cyc(2);
        chk("drain_def1_held", int'(dut.r_def_cnt[1]), 5);
        reqs = 4'b0000;
        cyc(1);
        chk("drain_def1_clr", int'(dut.r_def_cnt[1]), 0);
        chk("drain_busy", int'(busy), 0);
        reqs = 4'b0010;
        cyc(1);
        chk("drain_def1_new", int'(dut.r_def_cnt[1]), 13);
        chk("drain_cur_sel", int'(cur_sel), 1);
        chk_log("drain", e4);

        // Idle queues are skipped; no requests returns to IDLE.
        do_reset();
        set_all(8, 8);
        reqs = 4'b1001;
        cyc(8);
        chk_log("skip", e5);
        reqs = 4'b0000;
        cyc(1);
        chk("skip_busy", int'(busy), 0);
        chk("skip_gnt", int'(gnt), 0);

        // Stall freezes everything; reset then discards credit.
        do_reset();
        set_all(8, 16);
        reqs = 4'hF;
        cyc(2);
        blk = 1'b1;
        cyc(3);
        chk("blk_def0", int'(dut.r_def_cnt[0]), 8);
        chk("blk_cur_sel", int'(cur_sel), 0);
        blk = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        for (int i = 0; i < N; i++) chk($sformatf("rst_def%0d", i), int'(dut.r_def_cnt[i]), 0);
        chk("rst_cur_sel", int'(cur_sel), 3);
        rst = 1'b0;
        cyc(1);
        chk("rst_next_sel", int'(cur_sel), 0);
        chk("rst_next_def0", int'(dut.r_def_cnt[0]), 16);
        chk_log("blk", e6);

        // Credit saturates at 255 rather than wrapping.
        do_reset();
        set_all(63, 8);
        input_quantums[7:0] = 8'd250;
        reqs = 4'b0001;
        cyc(5);
        chk("sat_def0_a", int'(dut.r_def_cnt[0]), 255);
        cyc(5);
        chk("sat_def0_b", int'(dut.r_def_cnt[0]), 253);

        // Zero quantum and zero length (charged as 1).
        do_reset();
        set_all(0, 0);
        input_quantums[15:8] = 8'd1;
        reqs = 4'b0011;
        cyc(6);
        chk_log("zero", e8);

        log_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
